// File: rtl/anton_neopixel_frame_sequencer.sv
// Frame sequencer: drives stream ctrl init/run through N frames or a loop, counts frames, watchdogs stream events.
// Latency: all outputs are registered and update one clk7mhz edge after the deciding input.
// Backpressure: none; a start while busy is dropped, and a stop takes effect only at the next frame boundary.
module anton_neopixel_frame_sequencer #(
    parameter int FRAME_BITS  = 8,
    parameter int INIT_CYCLES = 4,
    parameter int WATCHDOG    = 65535
) (
    input  logic                  clk7mhz,
    input  logic                  rstn,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cfg_loop,
    input  logic [FRAME_BITS-1:0] cfg_frames,
    input  logic                  stream_pixel_of,
    input  logic                  stream_sync_of,
    output logic                  ctrl_init,
    output logic                  ctrl_run,
    output logic                  busy,
    output logic [FRAME_BITS-1:0] frame_count,
    output logic                  irq_done,
    output logic                  err_timeout,
    output logic [2:0]            seq_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT       = 3'd1,
        S_RUN        = 3'd2,
        S_RESET_WAIT = 3'd3,
        S_DONE       = 3'd4,
        S_ERROR      = 3'd5
    } state_t;

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WD_W   = 17;

    state_t                state_q, state_d;
    logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [FRAME_BITS-1:0] frame_d;
    logic                  err_d;
    logic [FRAME_BITS-1:0] frame_inc;
    logic [FRAME_BITS-1:0] frame_target;
    logic                  start_ok;
    logic                  wd_expired;

    assign frame_inc    = frame_count + FRAME_BITS'(1);
    assign frame_target = (cfg_frames == '0) ? FRAME_BITS'(1) : cfg_frames;
    assign start_ok     = cmd_start && !cmd_stop;
    assign wd_expired   = (wd_cnt_q == WD_W'(WATCHDOG - 1));
    assign seq_state    = state_q;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        stop_pend_d = stop_pend_q;
        frame_d     = frame_count;
        err_d       = err_timeout;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start_ok) begin
                    state_d     = S_INIT;
                    frame_d     = '0;
                    stop_pend_d = 1'b0;
                    init_cnt_d  = INIT_W'(INIT_CYCLES - 1);
                    err_d       = 1'b0;
                end
            end
            S_INIT: begin
                if (cmd_stop) stop_pend_d = 1'b1;
                if (init_cnt_q == '0) begin
                    state_d  = S_RUN;
                    wd_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q - INIT_W'(1);
                end
            end
            S_RUN: begin
                if (cmd_stop) stop_pend_d = 1'b1;
                // The awaited event beats a coincident timeout.
                if (stream_pixel_of) begin
                    state_d  = S_RESET_WAIT;
                    wd_cnt_d = '0;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            S_RESET_WAIT: begin
                if (cmd_stop) stop_pend_d = 1'b1;
                if (stream_sync_of) begin
                    frame_d = frame_inc;
                    if (stop_pend_q || cmd_stop || (!cfg_loop && frame_inc >= frame_target)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                        wd_cnt_d = '0;
                    end
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk7mhz or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            init_cnt_q  <= '0;
            wd_cnt_q    <= '0;
            stop_pend_q <= 1'b0;
            frame_count <= '0;
            err_timeout <= 1'b0;
            ctrl_init   <= 1'b0;
            ctrl_run    <= 1'b0;
            busy        <= 1'b0;
            irq_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            stop_pend_q <= stop_pend_d;
            frame_count <= frame_d;
            err_timeout <= err_d;
            // Decoded from next state so these flops line up with state_q.
            ctrl_init   <= (state_d == S_INIT);
            ctrl_run    <= (state_d == S_RUN) || (state_d == S_RESET_WAIT);
            busy        <= (state_d != S_IDLE) && (state_d != S_ERROR);
            irq_done    <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_anton_neopixel_frame_sequencer.sv
// Directed bench for anton_neopixel_frame_sequencer with a 16-cycle watchdog.
module tb_anton_neopixel_frame_sequencer;

    logic       clk7mhz = 1'b0;
    logic       rstn = 1'b1;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cfg_loop = 1'b0;
    logic [7:0] cfg_frames = 8'd0;
    logic       stream_pixel_of = 1'b0;
    logic       stream_sync_of = 1'b0;
    logic       ctrl_init;
    logic       ctrl_run;
    logic       busy;
    logic [7:0] frame_count;
    logic       irq_done;
    logic       err_timeout;
    logic [2:0] seq_state;

    int checks = 0;
    int errors = 0;

    anton_neopixel_frame_sequencer #(
        .FRAME_BITS (8),
        .INIT_CYCLES(4),
        .WATCHDOG   (16)
    ) dut (
        .clk7mhz        (clk7mhz),
        .rstn           (rstn),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cfg_loop       (cfg_loop),
        .cfg_frames     (cfg_frames),
        .stream_pixel_of(stream_pixel_of),
        .stream_sync_of (stream_sync_of),
        .ctrl_init      (ctrl_init),
        .ctrl_run       (ctrl_run),
        .busy           (busy),
        .frame_count    (frame_count),
        .irq_done       (irq_done),
        .err_timeout    (err_timeout),
        .seq_state      (seq_state)
    );

    always #71 clk7mhz = ~clk7mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk7mhz);
        #1;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
    endtask

    task automatic pulse_pix();
        stream_pixel_of = 1'b1;
        tick();
        stream_pixel_of = 1'b0;
    endtask

    task automatic pulse_sync();
        stream_sync_of = 1'b1;
        tick();
        stream_sync_of = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (seq_state !== 3'd2 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {29'd0, seq_state}, 32'd2);
    endtask

    initial begin
        int n;

        // Reset state
        #2 rstn = 1'b0;
        #3;
        chk("rst_state", {29'd0, seq_state}, 0);
        chk("rst_outs", {ctrl_init, ctrl_run, busy, irq_done, err_timeout}, 0);
        chk("rst_count", {24'd0, frame_count}, 0);
        tick();
        #20 rstn = 1'b1;
        tick();

        // One-shot, 3 frames
        cfg_loop = 1'b0;
        cfg_frames = 8'd3;
        pulse_start();
        chk("os_init_state", {29'd0, seq_state}, 1);
        chk("os_init_busy", {ctrl_init, ctrl_run, busy}, 3'b101);
        n = 1;
        while (ctrl_init && n < 20) begin
            tick();
            if (ctrl_init) n++;
        end
        chk("os_init_len", n, 4);
        chk("os_run_entry", {29'd0, seq_state}, 2);
        chk("os_run_ctrl", {ctrl_init, ctrl_run}, 2'b01);
        for (int f = 1; f <= 3; f++) begin
            tick();
            pulse_pix();
            chk("os_rw_state", {29'd0, seq_state}, 3);
            chk("os_rw_run", {31'd0, ctrl_run}, 1);
            pulse_sync();
            chk("os_frame_cnt", {24'd0, frame_count}, f);
            if (f < 3) begin
                chk("os_back_run", {29'd0, seq_state}, 2);
                chk("os_no_irq", {31'd0, irq_done}, 0);
            end
        end
        chk("os_done_state", {29'd0, seq_state}, 4);
        chk("os_done_outs", {ctrl_run, busy, irq_done}, 3'b011);
        tick();
        chk("os_idle_state", {29'd0, seq_state}, 0);
        chk("os_idle_outs", {busy, irq_done}, 0);
        chk("os_hold_cnt", {24'd0, frame_count}, 3);

        // Loop mode, stop requested mid-frame 2
        cfg_loop = 1'b1;
        cfg_frames = 8'd1;
        pulse_start();
        chk("lp_cnt_clear", {24'd0, frame_count}, 0);
        wait_run("lp_reach_run");
        pulse_pix();
        pulse_sync();
        chk("lp_f1_run", {29'd0, seq_state}, 2);
        chk("lp_f1_cnt", {24'd0, frame_count}, 1);
        pulse_stop();
        chk("lp_stop_no_abort", {29'd0, seq_state}, 2);
        chk("lp_stop_run_high", {31'd0, ctrl_run}, 1);
        pulse_pix();
        chk("lp_rw_run_high", {31'd0, ctrl_run}, 1);
        pulse_sync();
        chk("lp_done_state", {29'd0, seq_state}, 4);
        chk("lp_done_cnt", {24'd0, frame_count}, 2);
        chk("lp_irq", {31'd0, irq_done}, 1);
        tick();

        // Stop during INIT still sends one frame
        pulse_start();
        pulse_stop();
        chk("is_still_init", {29'd0, seq_state}, 1);
        wait_run("is_reach_run");
        pulse_pix();
        pulse_sync();
        chk("is_done_state", {29'd0, seq_state}, 4);
        chk("is_done_cnt", {24'd0, frame_count}, 1);
        tick();

        // cfg_frames = 0 behaves as 1
        cfg_loop = 1'b0;
        cfg_frames = 8'd0;
        pulse_start();
        wait_run("zf_reach_run");
        pulse_pix();
        pulse_sync();
        chk("zf_done_state", {29'd0, seq_state}, 4);
        chk("zf_cnt", {24'd0, frame_count}, 1);
        tick();

        // Start and stop together in IDLE
        cmd_start = 1'b1;
        cmd_stop = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        chk("ss_stay_idle", {29'd0, seq_state}, 0);
        chk("ss_not_busy", {31'd0, busy}, 0);

        // Start ignored while busy; stop coincident with sync_of
        cfg_frames = 8'd5;
        pulse_start();
        wait_run("ig_reach_run");
        pulse_start();
        chk("ig_start_run0", {29'd0, seq_state}, 2);
        chk("ig_cnt0", {24'd0, frame_count}, 0);
        pulse_pix();
        pulse_sync();
        pulse_start();
        chk("ig_start_run1", {29'd0, seq_state}, 2);
        chk("ig_cnt1", {24'd0, frame_count}, 1);
        pulse_pix();
        stream_sync_of = 1'b1;
        cmd_stop = 1'b1;
        tick();
        stream_sync_of = 1'b0;
        cmd_stop = 1'b0;
        chk("sc_done_state", {29'd0, seq_state}, 4);
        chk("sc_cnt", {24'd0, frame_count}, 2);
        tick();

        // Watchdog: event on the timeout cycle wins, then a real timeout in RESET_WAIT
        pulse_start();
        wait_run("wd_reach_run");
        for (int i = 0; i < 15; i++) tick();
        chk("wd_run_edge", {29'd0, seq_state}, 2);
        pulse_pix();
        chk("wd_event_wins", {29'd0, seq_state}, 3);
        chk("wd_no_err", {31'd0, err_timeout}, 0);
        for (int i = 0; i < 15; i++) tick();
        chk("wd_rw_edge", {29'd0, seq_state}, 3);
        tick();
        chk("wd_err_state", {29'd0, seq_state}, 5);
        chk("wd_err_outs", {err_timeout, ctrl_run, ctrl_init, busy}, 4'b1000);
        tick();
        chk("wd_sticky", {31'd0, err_timeout}, 1);
        pulse_start();
        chk("wd_restart_state", {29'd0, seq_state}, 1);
        chk("wd_err_cleared", {31'd0, err_timeout}, 0);

        // Asynchronous reset mid-RUN
        wait_run("ar_reach_run");
        pulse_pix();
        pulse_sync();
        #30 rstn = 1'b0;
        #1;
        chk("ar_state", {29'd0, seq_state}, 0);
        chk("ar_outs", {ctrl_init, ctrl_run, busy, irq_done, err_timeout}, 0);
        chk("ar_cnt", {24'd0, frame_count}, 0);
        #40 rstn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("ar_stays_idle", {29'd0, seq_state}, 0);
        pulse_start();
        chk("ar_new_start", {29'd0, seq_state}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/anton_neopixel_frame_sequencer.md
Name: anton_neopixel_frame_sequencer

Overview:
- Sequences the NeoPixel stream controller through whole frames.
- Drives its `ctrl_init`/`ctrl_run` controls and watches its `stream_pixel_of`/`stream_sync_of` events.
- Counts completed frames, supports one-shot N-frame and continuous loop modes, and performs a graceful stop at frame boundaries.
- Includes a watchdog on missing stream events; sits between the APB register block and the stream controller.

Parameters:
- `FRAME_BITS`, 8, width of the frame counter and of `cfg_frames`.
- `INIT_CYCLES`, 4, number of cycles `ctrl_init` is held before the first frame (minimum 1).
- `WATCHDOG`, 65535, maximum cycles allowed in RUN or RESET_WAIT without the expected stream event; must fit in 17 bits.

Ports:
- `clk7mhz`  in  1  system clock, 7 MHz.
- `rstn`  in  1  asynchronous active-low reset.
- `cmd_start`  in  1  single-cycle pulse; begin a sequence.
- `cmd_stop`  in  1  single-cycle pulse; request stop at the end of the current frame.
- `cfg_loop`  in  1  1 = run frames indefinitely; 0 = run `cfg_frames` frames.
- `cfg_frames`  in  FRAME_BITS  frame count for one-shot mode; 0 is treated as 1.
- `stream_pixel_of`  in  1  last bit of last pixel transmitted (from stream ctrl).
- `stream_sync_of`  in  1  reset/latch delay complete (from stream ctrl).
- `ctrl_init`  out  1  to stream ctrl `reg_ctrl_init`.
- `ctrl_run`  out  1  to stream ctrl `reg_ctrl_run`.
- `busy`  out  1  high in any state except IDLE and ERROR.
- `frame_count`  out  FRAME_BITS  frames completed since the last accepted start.
- `irq_done`  out  1  one-cycle pulse when a sequence ends normally.
- `err_timeout`  out  1  sticky watchdog error.
- `seq_state`  out  3  current state encoding, for debug and status.

Behaviour:
- **Reset (`rstn`=0, asynchronous):**
  - state = IDLE.
  - All outputs are 0, and `frame_count` is 0.
  - The stop-pending flag and the watchdog counter are cleared.
- **State encodings:** IDLE=0, INIT=1, RUN=2, RESET_WAIT=3, DONE=4, ERROR=5.
- **Registered signals:** all outputs and state update on the rising edge of `clk7mhz`; `ctrl_init` and `ctrl_run` are registered.
- **IDLE:**
  - `ctrl_init`=0, `ctrl_run`=0.
  - `cmd_start`=1 and `cmd_stop`=0 → INIT. This clears `frame_count` and stop-pending, and loads the init counter with `INIT_CYCLES`-1.
  - `cmd_start` and `cmd_stop` in the same cycle: stop wins and the sequencer stays in IDLE.
- **INIT:**
  - `ctrl_init`=1, `ctrl_run`=0 for exactly `INIT_CYCLES` cycles, then → RUN.
  - `ctrl_init` is 0 in the first RUN cycle.
- **RUN:**
  - `ctrl_run`=1.
  - On `stream_pixel_of` → RESET_WAIT, and the watchdog restarts.
- **RESET_WAIT:**
  - `ctrl_run` stays 1, because the stream ctrl counts its reset delay only while run is high.
  - On `stream_sync_of`, `frame_count` increments, wrapping at 2^FRAME_BITS.
  - Next state is DONE if stop-pending=1, or if `cfg_loop`=0 and the incremented count ≥ max(`cfg_frames`,1).
  - Otherwise the next state is RUN.
- **DONE:**
  - Lasts one cycle with `ctrl_run`=0 and `irq_done`=1, then → IDLE.
  - `frame_count` holds its value until the next accepted start.
- **ERROR:**
  - `ctrl_run`=0, `ctrl_init`=0, `err_timeout`=1 (sticky).
  - `cmd_start` clears `err_timeout` and → INIT, following the same rules as from IDLE.
- **Stop handling:**
  - `cmd_stop` in INIT, RUN or RESET_WAIT sets stop-pending; it is never an abort mid-frame.
  - `cmd_stop` in INIT lets one full frame be sent.
  - `cmd_stop` arriving in the same cycle as `stream_sync_of` is honoured for that frame boundary.
- **Ignored commands:** `cmd_start` while `busy`=1 is ignored. `cfg_loop` and `cfg_frames` are sampled live at each frame end.
- **Watchdog:**
  - The counter clears on entry to RUN or RESET_WAIT and increments each cycle in those states.
  - Reaching `WATCHDOG` without the awaited event → ERROR.
  - An awaited event occurring in the same cycle as the timeout wins; no error is raised.

Test Plan:
- **One-shot frames:** `cfg_loop`=0, `cfg_frames`=3, `cmd_start`, with pixel_of/sync_of emulated → `ctrl_init` high for 4 cycles, then 3 RUN/RESET_WAIT pairs; `irq_done` pulses once one cycle after the 3rd sync_of; `frame_count`=3; `busy` drops with IDLE.
- **Loop with stop:** `cfg_loop`=1, start, `cmd_stop` mid-frame 2 → frame 2 completes; DONE follows its sync_of; `frame_count`=2; `ctrl_run` never drops mid-frame.
- **Zero frames:** `cfg_frames`=0, `cfg_loop`=0 → exactly 1 frame; `frame_count`=1.
- **Watchdog:** `WATCHDOG`=16, start, no pixel_of → ERROR 16 cycles after RUN entry; `err_timeout`=1 and `ctrl_run`=0. A subsequent `cmd_start` clears `err_timeout` and re-enters INIT.
- **Simultaneous and ignored commands:**
  - Start+stop in the same cycle in IDLE → stays IDLE.
  - `cmd_start` during RUN → ignored, `frame_count` unchanged.
  - stop coincident with sync_of → DONE next cycle.
- **Asynchronous reset:** assert `rstn`=0 mid-RUN, asynchronously between clock edges → all outputs 0 immediately, `seq_state`=0; after release, resumes only on a new `cmd_start`.
